axi_w_replay_rab: RTL and testbench

- Sits on the read side of the RAB W-beat buffer and drains it onto the master-side AXI W channel.
- Per-burst commands come from the miss/translation logic: len = beats-1, drop = 1 on translation fault.
- Forwarded bursts get a regenerated w_last; dropped bursts are consumed silently and signalled with a done pulse.
- Keeps the W channel in AW order so that buffered beats are replayed or discarded exactly once.

---
 rtl/axi_rab_pkg.sv | 20 ++
 rtl/axi_w_replay_rab_cmd_fifo.sv | 93 +++++++++
 rtl/axi_w_replay_rab.sv | 157 +++++++++++++++
 tb/tb_axi_w_replay_rab.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rab_pkg.sv
// Shared types and constants for the RAB W-channel replay path.
package axi_rab_pkg;

  // Width of an AXI4 burst length field (AxLEN).
  localparam int unsigned RAB_AXI_LEN_WIDTH = 8;

  // Replay FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } rab_wstate_e;

  // One per-burst command from the miss/translation logic.
  typedef struct packed {
    logic [RAB_AXI_LEN_WIDTH-1:0] len;   // beats - 1
    logic                         drop;  // 1 = discard burst
  } rab_wcmd_t;

endpackage

// File: rtl/axi_w_replay_rab_cmd_fifo.sv
// Register-based circular command FIFO. Pushes are refused while full even
// when a pop happens in the same cycle, and a freshly pushed entry only
// becomes visible at the head in the following cycle.
module rab_cmd_fifo
  import axi_rab_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOG_DEPTH = 2,
  parameter type         elem_t    = rab_wcmd_t
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               flush_i,
  input  logic               push_i,
  input  elem_t              data_i,
  input  logic               pop_i,
  output elem_t              data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LOG_DEPTH:0] count_o
);

  localparam logic [LOG_DEPTH-1:0] LAST_IDX = LOG_DEPTH'(DEPTH - 1);
  localparam logic [LOG_DEPTH:0]   FULL_CNT = (LOG_DEPTH + 1)'(DEPTH);

  elem_t                mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q;
  logic [LOG_DEPTH-1:0] rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q;
  logic [LOG_DEPTH:0]   count_d;
  logic                 push_s;
  logic                 pop_s;

  // Pointer advance with explicit wrap so non power-of-two depths work.
  function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] ptr);
    if (ptr == LAST_IDX) begin
      return '0;
    end else begin
      return ptr + LOG_DEPTH'(1);
    end
  endfunction

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (LOG_DEPTH + 1)'(1);
      2'b01:   count_d = count_q - (LOG_DEPTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end else begin
      mem_q <= mem_q;
    end
  end

endmodule

// File: rtl/axi_w_replay_rab.sv
// Drains the RAB W-beat buffer onto the master W channel in AW order.
// Forwarded bursts get a regenerated w_last; dropped bursts are consumed
// silently and reported with a one-cycle drop_done pulse.
module axi_w_replay_rab
  import axi_rab_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CMD_DEPTH     = 4,
  parameter int unsigned LOG_CMD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid_i,
  input  logic [7:0]            cmd_len_i,
  input  logic                  cmd_drop_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  input  logic                  buf_valid_i,
  output logic                  buf_ready_o,
  output logic [DATA_WIDTH-1:0] w_data_o,
  output logic                  w_last_o,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic                  drop_done_o,
  input  logic                  flush_i,
  output logic                  busy_o
);

  rab_wstate_e                  state_q;
  rab_wstate_e                  state_d;
  logic [RAB_AXI_LEN_WIDTH-1:0] cnt_q;
  logic [RAB_AXI_LEN_WIDTH-1:0] cnt_d;
  logic                         drop_done_q;
  logic                         drop_done_d;

  rab_wcmd_t                    cmd_in_s;
  rab_wcmd_t                    cmd_head_s;
  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic                         fifo_push_s;
  logic                         fifo_pop_s;
  logic [LOG_CMD_DEPTH:0]       fifo_count_s;

  logic                         burst_end_s;
  logic                         buf_ready_s;
  logic                         w_valid_s;
  logic                         w_last_s;

  assign cmd_in_s    = '{len: cmd_len_i, drop: cmd_drop_i};
  assign fifo_push_s = cmd_valid_i & cmd_ready_o;

  rab_cmd_fifo #(
    .DEPTH     (CMD_DEPTH),
    .LOG_DEPTH (LOG_CMD_DEPTH),
    .elem_t    (rab_wcmd_t)
  ) u_cmd_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_i),
    .push_i  (fifo_push_s),
    .data_i  (cmd_in_s),
    .pop_i   (fifo_pop_s),
    .data_o  (cmd_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // FSM next-state and channel steering. Every path that finishes a burst
  // (or idles) raises burst_end_s, and the shared tail below loads the next
  // command in the same cycle so consecutive bursts run without a bubble.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_done_d = 1'b0;
    fifo_pop_s  = 1'b0;
    burst_end_s = 1'b0;
    buf_ready_s = 1'b0;
    w_valid_s   = 1'b0;
    w_last_s    = 1'b0;
    case (state_q)
      IDLE: begin
        burst_end_s = 1'b1;
      end
      FWD: begin
        w_valid_s   = buf_valid_i;
        buf_ready_s = w_ready_i;
        w_last_s    = (cnt_q == '0);
        if (buf_valid_i && w_ready_i) begin
          if (cnt_q == '0) begin
            burst_end_s = 1'b1;
          end else begin
            cnt_d = cnt_q - RAB_AXI_LEN_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DROP: begin
        buf_ready_s = 1'b1;
        if (buf_valid_i) begin
          if (cnt_q == '0) begin
            burst_end_s = 1'b1;
            drop_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - RAB_AXI_LEN_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (burst_end_s) begin
      if (!fifo_empty_s) begin
        fifo_pop_s = 1'b1;
        cnt_d      = cmd_head_s.len;
        state_d    = cmd_head_s.drop ? DROP : FWD;
      end else begin
        state_d = IDLE;
      end
    end else begin
      fifo_pop_s = 1'b0;
    end
  end

  // FSM, beat counter and drop_done pulse; reset wins over flush.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_done_q <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_done_q <= drop_done_d;
    end
  end

  // Outputs are forced to their idle values while rstn is low, before the
  // synchronous reset has taken effect on the state registers.
  assign cmd_ready_o = ~fifo_full_s | ~rstn;
  assign buf_ready_o = buf_ready_s & rstn;
  assign w_valid_o   = w_valid_s & rstn;
  assign w_last_o    = w_last_s & rstn;
  assign w_data_o    = buf_data_i;
  assign drop_done_o = drop_done_q;
  assign busy_o      = rstn & ((state_q != IDLE) | (fifo_count_s != '0));

endmodule

// File: tb/tb_axi_w_replay_rab.sv
// Scoreboard bench for axi_w_replay_rab: the buffer is modelled as a queue,
// expected W beats are queued when stimulus is driven and popped on each
// observed W handshake.
module tb_axi_w_replay_rab;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid_i;
  logic [7:0]    cmd_len_i;
  logic          cmd_drop_i;
  logic          cmd_ready_o;
  logic [DW-1:0] buf_data_i;
  logic          buf_valid_i;
  logic          buf_ready_o;
  logic [DW-1:0] w_data_o;
  logic          w_last_o;
  logic          w_valid_o;
  logic          w_ready_i;
  logic          drop_done_o;
  logic          flush_i;
  logic          busy_o;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] bufq[$];
  beat_t         expq[$];

  axi_w_replay_rab #(
    .DATA_WIDTH    (DW),
    .CMD_DEPTH     (4),
    .LOG_CMD_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd_valid_i (cmd_valid_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_drop_i  (cmd_drop_i),
    .cmd_ready_o (cmd_ready_o),
    .buf_data_i  (buf_data_i),
    .buf_valid_i (buf_valid_i),
    .buf_ready_o (buf_ready_o),
    .w_data_o    (w_data_o),
    .w_last_o    (w_last_o),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .drop_done_o (drop_done_o),
    .flush_i     (flush_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Present the head of the FWFT buffer model.
  task automatic drive_buf();
    buf_valid_i = (bufq.size() != 0);
    buf_data_i  = (bufq.size() != 0) ? bufq[0] : '0;
  endtask

  // Advance one clock; inputs change and outputs are sampled around negedge.
  task automatic tick();
    bit consume;
    consume = buf_ready_o && buf_valid_i;
    @(posedge clk);
    @(negedge clk);
    if (consume) bufq.delete(0);
    drive_buf();
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush_i = 1'b0; cmd_valid_i = 1'b0; cmd_len_i = 8'd0;
    cmd_drop_i = 1'b0; w_ready_i = 1'b1;
    bufq.delete(); drive_buf();
    repeat (3) tick();
    #1;
    n_checks++;
    if ({cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o, drop_done_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy/brdy/wv/wl/busy/dd=%b expected 100000",
               {cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o, drop_done_o});
    end
    rstn = 1'b1;
    tick();
  endtask

  // Single forwarded burst of len+1 beats, optionally with 1,0,1,0 backpressure.
  task automatic test_fwd_burst(input int len, input bit stall, input string nm);
    int            hs;
    int            first_c;
    int            last_c;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] d;
    beat_t         e;
    hs = 0; first_c = -1; last_c = -1; prev_stall = 1'b0; prev_data = '0;
    for (int i = 0; i <= len; i++) begin
      d = $urandom();
      bufq.push_back(d);
      expq.push_back('{data: d, last: (i == len)});
    end
    drive_buf();
    cmd_valid_i = 1'b1; cmd_len_i = 8'(len); cmd_drop_i = 1'b0; w_ready_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 2 * len + 20 && hs <= len; cyc++) begin
      w_ready_i = stall ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (prev_stall) begin
        n_checks++;
        if (w_valid_o !== 1'b1 || w_data_o !== prev_data) begin
          n_fail++;
          $display("FAIL %s_stall_hold: got valid=%b data=%h expected valid=1 data=%h",
                   nm, w_valid_o, w_data_o, prev_data);
        end
      end
      prev_stall = w_valid_o && !w_ready_i;
      prev_data  = w_data_o;
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        if (buf_ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_buf_ready: got %b expected 1", nm, buf_ready_o);
        end
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra_beat: got data=%h with no beat expected", nm, w_data_o);
        end else begin
          e = expq.pop_front();
          if ({w_data_o, w_last_o} !== e) begin
            n_fail++;
            $display("FAIL %s_beat%0d: got data=%h last=%b expected data=%h last=%b",
                     nm, hs, w_data_o, w_last_o, e.data, e.last);
          end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        hs++;
      end
      tick();
    end
    w_ready_i = 1'b1;
    #1;
    n_checks++;
    if (hs != len + 1) begin
      n_fail++;
      $display("FAIL %s_handshakes: got %0d expected %0d", nm, hs, len + 1);
    end
    if (!stall) begin
      n_checks++;
      if (last_c - first_c != len) begin
        n_fail++;
        $display("FAIL %s_consecutive: got span %0d expected %0d", nm, last_c - first_c, len);
      end
    end
    n_checks++;
    if (busy_o !== 1'b0 || w_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_after: got busy=%b valid=%b expected 0 0", nm, busy_o, w_valid_o);
    end
    expq.delete();
  endtask

  // Dropped burst followed immediately by a single-beat forwarded burst.
  task automatic test_drop_then_fwd();
    int    d1_c;
    int    dd_c;
    int    dd_n;
    int    e_c;
    int    hs;
    beat_t e;
    d1_c = -1; dd_c = -1; dd_n = 0; e_c = -1; hs = 0;
    bufq.push_back(32'hD0D0_0000);
    bufq.push_back(32'hD1D1_0001);
    bufq.push_back(32'hE0E0_0002);
    expq.push_back('{data: 32'hE0E0_0002, last: 1'b1});
    drive_buf();
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_len_i = 8'd1; cmd_drop_i = 1'b1;
    tick();
    cmd_len_i = 8'd0; cmd_drop_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (buf_ready_o && buf_valid_i && !w_valid_o && buf_data_i === 32'hD1D1_0001) d1_c = cyc;
      if (drop_done_o === 1'b1) begin
        dd_n++;
        dd_c = cyc;
      end
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL drop_extra_beat: got data=%h with no beat expected", w_data_o);
        end else begin
          e = expq.pop_front();
          if ({w_data_o, w_last_o} !== e) begin
            n_fail++;
            $display("FAIL drop_fwd_beat: got data=%h last=%b expected data=%h last=%b",
                     w_data_o, w_last_o, e.data, e.last);
          end
        end
        e_c = cyc;
        hs++;
      end
      tick();
    end
    n_checks++;
    if (hs != 1 || e_c != d1_c + 1 || d1_c < 0) begin
      n_fail++;
      $display("FAIL drop_fwd_timing: got handshakes=%0d E0 cycle=%0d D1 cycle=%0d expected 1 beat one cycle after D1",
               hs, e_c, d1_c);
    end
    n_checks++;
    if (dd_n != 1 || dd_c != d1_c + 1) begin
      n_fail++;
      $display("FAIL drop_done_pulse: got %0d pulses at cycle %0d expected 1 at cycle %0d",
               dd_n, dd_c, d1_c + 1);
    end
    n_checks++;
    if (busy_o !== 1'b0 || bufq.size() != 0) begin
      n_fail++;
      $display("FAIL drop_idle_after: got busy=%b buffer left=%0d expected 0 0", busy_o, bufq.size());
    end
    expq.delete();
  endtask

  // Two forwarded bursts queued back to back must stream with no bubble.
  task automatic test_back_to_back();
    int            hs;
    int            first_c;
    int            last_c;
    logic [DW-1:0] d;
    beat_t         e;
    hs = 0; first_c = -1; last_c = -1;
    for (int i = 0; i < 3; i++) begin
      d = $urandom();
      bufq.push_back(d);
      expq.push_back('{data: d, last: (i != 0)});
    end
    drive_buf();
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_len_i = 8'd1; cmd_drop_i = 1'b0;
    tick();
    cmd_len_i = 8'd0;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 15 && hs < 3; cyc++) begin
      #1;
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_beat: got data=%h with no beat expected", w_data_o);
        end else begin
          e = expq.pop_front();
          if ({w_data_o, w_last_o} !== e) begin
            n_fail++;
            $display("FAIL b2b_beat%0d: got data=%h last=%b expected data=%h last=%b",
                     hs, w_data_o, w_last_o, e.data, e.last);
          end
        end
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        hs++;
      end
      tick();
    end
    n_checks++;
    if (hs != 3 || last_c - first_c != 2) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: got %0d beats over span %0d expected 3 over 2", hs, last_c - first_c);
    end
    expq.delete();
  endtask

  // Fill the command FIFO, check refusal when full even with a same-cycle pop.
  task automatic test_fifo_full();
    int            acc;
    int            hs;
    logic [DW-1:0] d;
    beat_t         e;
    acc = 0; hs = 0;
    bufq.delete(); drive_buf();
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_len_i = 8'd0; cmd_drop_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (cmd_ready_o) acc++;
      tick();
    end
    cmd_valid_i = 1'b0;
    #1;
    n_checks++;
    if (acc != 5 || cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_accept: got accepted=%0d ready=%b busy=%b expected 5 0 1", acc, cmd_ready_o, busy_o);
    end
    // Full plus pop in the same cycle: a drop command offered now is refused.
    cmd_valid_i = 1'b1; cmd_len_i = 8'd0; cmd_drop_i = 1'b1;
    d = $urandom();
    bufq.push_back(d);
    expq.push_back('{data: d, last: 1'b1});
    drive_buf();
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      bufq.push_back(d);
      expq.push_back('{data: d, last: 1'b1});
    end
    #1;
    n_checks++;
    if (cmd_ready_o !== 1'b0 || w_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_cycle: got ready=%b valid=%b expected 0 1", cmd_ready_o, w_valid_o);
    end
    for (int cyc = 0; cyc < 20 && hs < 5; cyc++) begin
      if (cyc == 1) begin
        cmd_valid_i = 1'b0;
      end
      #1;
      if (cyc == 1) begin
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
          n_fail++;
          $display("FAIL full_ready_reraise: got %b expected 1", cmd_ready_o);
        end
      end
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL full_extra_beat: got data=%h with no beat expected", w_data_o);
        end else begin
          e = expq.pop_front();
          if ({w_data_o, w_last_o} !== e) begin
            n_fail++;
            $display("FAIL full_beat%0d: got data=%h last=%b expected data=%h last=%b",
                     hs, w_data_o, w_last_o, e.data, e.last);
          end
        end
        hs++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (hs != 5 || busy_o !== 1'b0 || bufq.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got beats=%0d busy=%b buffer left=%0d expected 5 0 0", hs, busy_o, bufq.size());
    end
    bufq.delete(); expq.delete(); drive_buf();
  endtask

  // Flush after three beats of an 8-beat burst with a second command queued.
  task automatic test_flush();
    int            hs;
    bit            bad;
    logic [DW-1:0] d;
    beat_t         e;
    hs = 0; bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      bufq.push_back(d);
      if (i < 3) expq.push_back('{data: d, last: 1'b0});
    end
    drive_buf();
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_len_i = 8'd7; cmd_drop_i = 1'b0;
    tick();
    cmd_len_i = 8'd0;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 20 && hs < 3; cyc++) begin
      #1;
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        e = expq.pop_front();
        if ({w_data_o, w_last_o} !== e) begin
          n_fail++;
          $display("FAIL flush_beat%0d: got data=%h last=%b expected data=%h last=%b",
                   hs, w_data_o, w_last_o, e.data, e.last);
        end
        hs++;
      end
      tick();
    end
    flush_i = 1'b1;
    bufq.delete(); drive_buf();
    #1;
    tick();
    flush_i = 1'b0;
    #1;
    n_checks++;
    if (hs != 3 || busy_o !== 1'b0 || w_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear: got beats=%0d busy=%b valid=%b ready=%b expected 3 0 0 1",
               hs, busy_o, w_valid_o, cmd_ready_o);
    end
    bufq.push_back(32'hBAD0_BEEF); drive_buf();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (w_valid_o !== 1'b0 || buf_ready_o !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL flush_no_traffic: got W valid or buffer pop after flush expected none");
    end
    bufq.delete(); expq.delete(); drive_buf();
  endtask

  // One-cycle reset mid-burst, then a single-beat burst must work normally.
  task automatic test_reset_mid();
    int            hs;
    logic [DW-1:0] d;
    beat_t         e;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom();
      bufq.push_back(d);
    end
    drive_buf();
    w_ready_i = 1'b1;
    cmd_valid_i = 1'b1; cmd_len_i = 8'd3; cmd_drop_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 10 && hs < 1; cyc++) begin
      #1;
      if (w_valid_o && w_ready_i) hs++;
      tick();
    end
    rstn = 1'b0;
    bufq.delete(); drive_buf();
    #1;
    n_checks++;
    if ({cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rst_mid_during: got rdy/brdy/wv/wl/busy=%b expected 10000",
               {cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o});
    end
    tick();
    rstn = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o, drop_done_o} !== 6'b100000) begin
      n_fail++;
      $display("FAIL rst_mid_after: got rdy/brdy/wv/wl/busy/dd=%b expected 100000",
               {cmd_ready_o, buf_ready_o, w_valid_o, w_last_o, busy_o, drop_done_o});
    end
    hs = 0;
    d = $urandom();
    bufq.push_back(d);
    expq.push_back('{data: d, last: 1'b1});
    drive_buf();
    cmd_valid_i = 1'b1; cmd_len_i = 8'd0; cmd_drop_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    for (int cyc = 0; cyc < 10 && hs < 1; cyc++) begin
      #1;
      if (w_valid_o && w_ready_i) begin
        n_checks++;
        e = expq.pop_front();
        if ({w_data_o, w_last_o} !== e) begin
          n_fail++;
          $display("FAIL rst_mid_beat: got data=%h last=%b expected data=%h last=%b",
                   w_data_o, w_last_o, e.data, e.last);
        end
        hs++;
      end
      tick();
    end
    #1;
    n_checks++;
    if (hs != 1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_recover: got beats=%0d busy=%b expected 1 0", hs, busy_o);
    end
    expq.delete();
  endtask

  initial begin
    test_reset();
    test_fwd_burst(3, 1'b0, "fwd4");
    test_fwd_burst(3, 1'b1, "stall4");
    test_fwd_burst(0, 1'b0, "single");
    test_drop_then_fwd();
    test_back_to_back();
    test_fifo_full();
    test_flush();
    test_reset_mid();
    test_fwd_burst(255, 1'b0, "len255");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
